array_write_loader: RTL and testbench
=====================================

# array_write_loader

Sequential write engine for the 16×8 RAM array that the reduce-sum and display path reads. It accepts bytes over a valid/ready handshake and writes them to consecutive addresses starting at 0. It tracks the fill count and can sweep the whole array to zero on command. It drives the RAM write port in place of direct switch-addressed writes.

## Interface
- DEPTH, 16, number of RAM entries; power of two
- ADDR_WIDTH, 4, RAM address width; log2(DEPTH)
- DATA_WIDTH, 8, RAM word width
- WRAP, 0, 0 = stop accepting when full; 1 = wrap pointer and overwrite oldest
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- clear  input  1  single-cycle pulse (already debounced); request zero-sweep of array
- inValid  input  1  inData is valid this cycle
- inData  input  DATA_WIDTH  byte to store
- inReady  output  1  loader accepts inData this cycle (combinational)
- memWriteEnable  output  1  registered RAM write strobe
- memWriteAddress  output  ADDR_WIDTH  registered RAM write address
- memWriteData  output  DATA_WIDTH  registered RAM write data
- count  output  ADDR_WIDTH+1  number of valid entries, 0..DEPTH
- full  output  1  count == DEPTH
- busy  output  1  state != IDLE

## Operation
- States: IDLE, WRITE, CLEAR. The internal write pointer wp has ADDR_WIDTH bits.
- inReady = (state==IDLE) & ~clear & (~full | WRAP).
- Accept = inValid & inReady. On accept, latch inData and wp, then go to WRITE.
- WRITE lasts one cycle:
  - memWriteEnable=1, address=latched wp, data=latched byte.
  - wp <= wp+1, wrapping DEPTH-1 -> 0.
  - count <= min(count+1, DEPTH).
  - Next state: CLEAR if a clear is pending, else IDLE.
- Clear in IDLE goes to CLEAR and takes priority over a simultaneous inValid; that byte is not accepted.
- Clear arriving during WRITE sets a pending flag. CLEAR begins the cycle after WRITE.
- Clear arriving during CLEAR is ignored.
- CLEAR lasts exactly DEPTH cycles:
  - memWriteEnable=1, memWriteData=0, addresses 0,1,...,DEPTH-1 in order.
  - On the last cycle: wp<=0, count<=0, pending<=0, then go to IDLE.
- WRAP=0: once full, inReady stays low until a clear completes.
- WRAP=1: while full, accepts continue. wp wraps and count stays at DEPTH.
- Reset:
  - state=IDLE, wp=0, count=0, pending=0.
  - memWriteEnable=0, memWriteAddress=0, memWriteData=0.
  - RAM contents are not swept.
- Reset during CLEAR or WRITE aborts it immediately. No further write strobes occur.

## Timing
- Accept at posedge k leads to the RAM write strobe during cycle k+1 (one-cycle latency). count and full update at the end of cycle k+1.
- Peak throughput is one byte per 2 cycles. inReady is low during WRITE.
- Clear accepted at edge k: zero writes occupy cycles k+1..k+DEPTH. busy drops and inReady may rise in cycle k+DEPTH+1.
- Clear pending from WRITE at edge k: the byte is written in k+1 and the sweep occupies k+2..k+DEPTH+1. The byte is overwritten and count ends at 0.
- busy is high in every cycle where memWriteEnable is high.
- memWriteEnable is never high in two states at once. Exactly one write occurs per WRITE cycle and per CLEAR cycle.

## Test plan
- Reset, then feed 0x11,0x22,0x33 with inValid held high -> writes (0,0x11),(1,0x22),(2,0x33) on alternate cycles; count=3; full=0.
- WRAP=0, feed 16 bytes 0x00..0x0F, then 0xAA -> 16 writes at addresses 0..15; full=1, count=16; inReady stays 0; 0xAA is never written.
- WRAP=1, feed 17 bytes 0x00..0x10 -> the 17th write is (0,0x10); count=16; full=1; inReady=1.
- After 5 bytes, pulse clear -> 16 consecutive writes of 0x00 to addresses 0..15; busy high for 16 cycles; then count=0 and the next byte goes to address 0.
- clear and inValid in the same IDLE cycle -> byte not accepted (inReady=0); sweep runs. Clear during WRITE -> byte written first, then the sweep starts the next cycle.
- Assert reset on the 7th cycle of CLEAR -> the next cycle has memWriteEnable=0, count=0, busy=0, and address/data outputs at 0.

Source files
------------

// File: rtl/array_write_loader.sv
// Sequential write engine for the display RAM: stores handshaked bytes at
// consecutive addresses, tracks the fill count and can sweep the array to zero.
module array_write_loader #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WRAP       = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inValid,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic                  inReady,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memWriteAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic                  WRAP_EN     = (WRAP != 0);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wp;
    logic                  pending;
    logic                  accept;

    assign full    = (count == DEPTH_COUNT);
    assign busy    = (state != IDLE);
    assign inReady = (state == IDLE) && !clear && (!full || WRAP_EN);
    assign accept  = inValid && inReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            wp              <= '0;
            count           <= '0;
            pending         <= 1'b0;
            memWriteEnable  <= 1'b0;
            memWriteAddress <= '0;
            memWriteData    <= '0;
        end else begin
            memWriteEnable <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state           <= CLEAR;
                        memWriteEnable  <= 1'b1;
                        memWriteAddress <= '0;
                        memWriteData    <= '0;
                    end else if (accept) begin
                        state           <= WRITE;
                        memWriteEnable  <= 1'b1;
                        memWriteAddress <= wp;
                        memWriteData    <= inData;
                    end
                end
                WRITE: begin
                    // Pointer wraps naturally because DEPTH is a power of two.
                    wp    <= wp + 1'b1;
                    count <= full ? count : count + 1'b1;
                    if (clear || pending) begin
                        state           <= CLEAR;
                        pending         <= 1'b1;
                        memWriteEnable  <= 1'b1;
                        memWriteAddress <= '0;
                        memWriteData    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    // The write address doubles as the sweep index.
                    if (memWriteAddress == LAST_ADDR) begin
                        state   <= IDLE;
                        wp      <= '0;
                        count   <= '0;
                        pending <= 1'b0;
                    end else begin
                        memWriteEnable  <= 1'b1;
                        memWriteAddress <= memWriteAddress + 1'b1;
                        memWriteData    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_write_loader.sv
// Directed bench for array_write_loader: table-driven handshake vectors plus
// hand-written sweep, clear-during-write, reset-abort and fill/wrap sequences.
module tb_array_write_loader;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid;
    logic [7:0] in_data, in_data1;

    logic       ready0, we0, full0, busy0;
    logic [3:0] addr0;
    logic [7:0] data0;
    logic [4:0] count0;
    logic       ready1, we1, full1, busy1;
    logic [3:0] addr1;
    logic [7:0] data1;
    logic [4:0] count1;

    int tests  = 0;
    int failed = 0;

    array_write_loader #(.DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(8), .WRAP(0)) dut0 (
        .clock(clk), .reset(reset), .clear(clear), .inValid(in_valid), .inData(in_data),
        .inReady(ready0), .memWriteEnable(we0), .memWriteAddress(addr0),
        .memWriteData(data0), .count(count0), .full(full0), .busy(busy0)
    );

    array_write_loader #(.DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(8), .WRAP(1)) dut1 (
        .clock(clk), .reset(reset), .clear(clear), .inValid(in_valid), .inData(in_data1),
        .inReady(ready1), .memWriteEnable(we1), .memWriteAddress(addr1),
        .memWriteData(data1), .count(count1), .full(full1), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, c, v;
        logic [7:0] d;
        int         rdy, we, addr, dat, cnt, busy;
        bit         chk, chk_ad;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [7:0] d, input logic [7:0] d1);
        @(negedge clk);
        reset = r; clear = c; in_valid = v; in_data = d; in_data1 = d1;
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_data1 = '0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0,     0, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h11, 1, 0, 0, 0,     0, 0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h22, 0, 1, 0, 8'h11, 0, 1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h22, 1, 0, 0, 0,     1, 0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h33, 0, 1, 1, 8'h22, 1, 1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h33, 1, 0, 0, 0,     2, 0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 2, 8'h33, 2, 1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 0, 0,     3, 0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h44, 0, 0, 0, 0,     3, 0, 1'b1, 1'b0};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].d, vecs[i].d);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_ready", i), int'(ready0), vecs[i].rdy);
                check($sformatf("v%0d_we", i),    int'(we0),    vecs[i].we);
                check($sformatf("v%0d_count", i), int'(count0), vecs[i].cnt);
                check($sformatf("v%0d_full", i),  int'(full0),  int'(vecs[i].cnt == 16));
                check($sformatf("v%0d_busy", i),  int'(busy0),  vecs[i].busy);
                if (vecs[i].chk_ad) begin
                    check($sformatf("v%0d_addr", i), int'(addr0), vecs[i].addr);
                    check($sformatf("v%0d_data", i), int'(data0), vecs[i].dat);
                end
            end
        end

        // Sweep from the clear that blocked 0x44.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            check($sformatf("swA%0d_we", i),    int'(we0),    1);
            check($sformatf("swA%0d_addr", i),  int'(addr0),  i);
            check($sformatf("swA%0d_data", i),  int'(data0),  0);
            check($sformatf("swA%0d_busy", i),  int'(busy0),  1);
            check($sformatf("swA%0d_ready", i), int'(ready0), 0);
        end
        step(1'b0, 1'b0, 1'b1, 8'h55, 8'h55);
        check("postA_we",    int'(we0),    0);
        check("postA_busy",  int'(busy0),  0);
        check("postA_count", int'(count0), 0);
        check("postA_ready", int'(ready0), 1);

        // Clear during WRITE: byte lands first, sweep follows immediately.
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("wrB_we",    int'(we0),    1);
        check("wrB_addr",  int'(addr0),  0);
        check("wrB_data",  int'(data0),  8'h55);
        check("wrB_ready", int'(ready0), 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            check($sformatf("swB%0d_we", i),    int'(we0),    1);
            check($sformatf("swB%0d_addr", i),  int'(addr0),  i);
            check($sformatf("swB%0d_data", i),  int'(data0),  0);
            check($sformatf("swB%0d_count", i), int'(count0), 1);
        end
        step(1'b0, 1'b0, 1'b1, 8'h66, 8'h66);
        check("postB_we",    int'(we0),    0);
        check("postB_count", int'(count0), 0);
        check("postB_busy",  int'(busy0),  0);

        // Two bytes, then a sweep aborted by reset on its 7th cycle.
        step(1'b0, 1'b0, 1'b1, 8'h77, 8'h77);
        check("c_wr0_addr", int'(addr0), 0);
        check("c_wr0_data", int'(data0), 8'h66);
        step(1'b0, 1'b0, 1'b1, 8'h77, 8'h77);
        check("c_idle_count", int'(count0), 1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("c_wr1_addr", int'(addr0), 1);
        check("c_wr1_data", int'(data0), 8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("c_clr_ready", int'(ready0), 0);
        check("c_clr_count", int'(count0), 2);
        for (int c = 1; c <= 7; c++) begin
            step(c == 7, c == 3, 1'b0, 8'h00, 8'h00);
            check($sformatf("swC%0d_we", c),    int'(we0),    1);
            check($sformatf("swC%0d_addr", c),  int'(addr0),  c - 1);
            check($sformatf("swC%0d_count", c), int'(count0), 2);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            check($sformatf("abort%0d_we", i),   int'(we0),   0);
            check($sformatf("abort%0d_busy", i), int'(busy0), 0);
            if (i == 0) begin
                check("abort_addr",  int'(addr0),  0);
                check("abort_data",  int'(data0),  0);
                check("abort_count", int'(count0), 0);
            end
        end

        // Fill to DEPTH on both variants, then offer one extra byte.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(i), 8'(i));
            check($sformatf("fill%0d_ready0", i), int'(ready0), 1);
            check($sformatf("fill%0d_ready1", i), int'(ready1), 1);
            check($sformatf("fill%0d_count0", i), int'(count0), i);
            step(1'b0, 1'b0, 1'b1, 8'(i), 8'(i));
            check($sformatf("fill%0d_we0", i),   int'(we0),   1);
            check($sformatf("fill%0d_addr0", i), int'(addr0), i);
            check($sformatf("fill%0d_data0", i), int'(data0), i);
            check($sformatf("fill%0d_addr1", i), int'(addr1), i);
            check($sformatf("fill%0d_data1", i), int'(data1), i);
        end
        step(1'b0, 1'b0, 1'b1, 8'hAA, 8'h10);
        check("full0_ready", int'(ready0), 0);
        check("full0_flag",  int'(full0),  1);
        check("full0_count", int'(count0), 16);
        check("full1_ready", int'(ready1), 1);
        check("full1_flag",  int'(full1),  1);
        check("full1_count", int'(count1), 16);
        step(1'b0, 1'b0, 1'b1, 8'hAA, 8'h10);
        check("wrap1_we",   int'(we1),   1);
        check("wrap1_addr", int'(addr1), 0);
        check("wrap1_data", int'(data1), 8'h10);
        check("hold0_we",   int'(we0),   0);
        step(1'b0, 1'b0, 1'b0, 8'hAA, 8'h00);
        check("wrap1_count", int'(count1), 16);
        check("wrap1_full",  int'(full1),  1);
        check("wrap1_ready", int'(ready1), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'hAA, 8'h00);
            check($sformatf("stuck%0d_ready0", i), int'(ready0), 0);
            check($sformatf("stuck%0d_we0", i),    int'(we0),    0);
            check($sformatf("stuck%0d_count0", i), int'(count0), 16);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
